// File: rtl/blink_sequencer.sv
// Three-channel LED blink controller: one shared prescaler tick feeds three
// period counters and a chase index, and a button-stepped mode FSM picks the pattern.
module blink_sequencer #(
  parameter int TICK_DIV   = 50,
  parameter int HALF0      = 1,
  parameter int HALF1      = 2,
  parameter int HALF2      = 4,
  parameter int CHASE_STEP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       btn_next,
  output logic [2:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STP_W = (CHASE_STEP > 1) ? $clog2(CHASE_STEP) : 1;
  localparam int CH0_W = (2 * HALF0 > 1) ? $clog2(2 * HALF0) : 1;
  localparam int CH1_W = (2 * HALF1 > 1) ? $clog2(2 * HALF1) : 1;
  localparam int CH2_W = (2 * HALF2 > 1) ? $clog2(2 * HALF2) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [STP_W-1:0] STP_MAX  = STP_W'(CHASE_STEP - 1);
  localparam logic [CH0_W-1:0] CH0_MAX  = CH0_W'(2 * HALF0 - 1);
  localparam logic [CH1_W-1:0] CH1_MAX  = CH1_W'(2 * HALF1 - 1);
  localparam logic [CH2_W-1:0] CH2_MAX  = CH2_W'(2 * HALF2 - 1);
  localparam logic [CH0_W-1:0] CH0_HALF = CH0_W'(HALF0);
  localparam logic [CH1_W-1:0] CH1_HALF = CH1_W'(HALF1);
  localparam logic [CH2_W-1:0] CH2_HALF = CH2_W'(HALF2);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_ALT   = 2'b11
  } mode_t;

  mode_t            state;
  mode_t            state_next;
  logic             btn_q;
  logic             btn_edge;
  logic [PRE_W-1:0] pre;
  logic [STP_W-1:0] stp;
  logic [1:0]       idx;
  logic [CH0_W-1:0] ch0;
  logic [CH1_W-1:0] ch1;
  logic [CH2_W-1:0] ch2;
  logic             on0;
  logic             on1;
  logic             on2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_next;
    end
  end

  assign btn_edge = btn_next & ~btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MODE_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (btn_edge) begin
      case (state)
        MODE_OFF:   state_next = MODE_BLINK;
        MODE_BLINK: state_next = MODE_CHASE;
        MODE_CHASE: state_next = MODE_ALT;
        MODE_ALT:   state_next = MODE_OFF;
        default:    state_next = MODE_OFF;
      endcase
    end
  end

  assign mode = state;

  // rst_n gates tick so it reads 0 during reset even when TICK_DIV is 1.
  assign tick = en & rst_n & (pre == PRE_MAX);

  // A mode change clears all timing and takes priority over a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      ch0 <= '0;
      ch1 <= '0;
      ch2 <= '0;
      stp <= '0;
      idx <= '0;
    end else if (btn_edge) begin
      pre <= '0;
      ch0 <= '0;
      ch1 <= '0;
      ch2 <= '0;
      stp <= '0;
      idx <= '0;
    end else begin
      if (en) begin
        pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
      end
      if (tick) begin
        ch0 <= (ch0 == CH0_MAX) ? '0 : ch0 + 1'b1;
        ch1 <= (ch1 == CH1_MAX) ? '0 : ch1 + 1'b1;
        ch2 <= (ch2 == CH2_MAX) ? '0 : ch2 + 1'b1;
      end
      if (state != MODE_CHASE) begin
        stp <= '0;
        idx <= '0;
      end else if (tick) begin
        if (stp == STP_MAX) begin
          stp <= '0;
          idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
          stp <= stp + 1'b1;
        end
      end
    end
  end

  assign on0 = (ch0 < CH0_HALF);
  assign on1 = (ch1 < CH1_HALF);
  assign on2 = (ch2 < CH2_HALF);

  always_comb begin
    led = 3'b000;
    case (state)
      MODE_OFF:   led = 3'b000;
      MODE_BLINK: led = {on2, on1, on0};
      MODE_CHASE: led = 3'b001 << idx;
      MODE_ALT:   led = {on0, ~on0, on0};
      default:    led = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// Testbench for blink_sequencer: a vector table for the start-up sequence,
// hand-written corner sequences, and random stimulus against a tick-count model.
module tb_blink_sequencer;

  localparam int TD = 4;
  localparam int H0 = 1;
  localparam int H1 = 2;
  localparam int H2 = 4;
  localparam int CS = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       btn_next;
  logic [2:0] led;
  logic [1:0] mode;
  logic       tick;

  int checks;
  int errors;

  // Reference model: mode, enabled cycles since last clear, ticks since last clear.
  int mMode;
  int mE;
  int mT;
  bit mBtnPrev;

  typedef struct {
    logic       btn;
    logic       en;
    logic [2:0] led;
    logic [1:0] mode;
    logic       tick;
  } vec_t;

  vec_t vecs [14];

  blink_sequencer #(
    .TICK_DIV  (TD),
    .HALF0     (H0),
    .HALF1     (H1),
    .HALF2     (H2),
    .CHASE_STEP(CS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .btn_next(btn_next),
    .led     (led),
    .mode    (mode),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] modelLed();
    logic [2:0] r;
    r = 3'b000;
    case (mMode)
      1: begin
        r[0] = (mT % (2 * H0)) < H0;
        r[1] = (mT % (2 * H1)) < H1;
        r[2] = (mT % (2 * H2)) < H2;
      end
      2: r = 3'b001 << ((mT / CS) % 3);
      3: begin
        r[0] = (mT % (2 * H0)) < H0;
        r[1] = ~r[0];
        r[2] = r[0];
      end
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic modelTick();
    return en && rst_n && ((mE % TD) == TD - 1);
  endfunction

  task automatic applyStimulus(input logic b, input logic e);
    btn_next = b;
    en = e;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expLed,
                             input logic [1:0] expMode, input logic expTick);
    checks++;
    if (led !== expLed || mode !== expMode || tick !== expTick) begin
      errors++;
      $display("[TB] FAIL %s: got led=%b mode=%b tick=%b, expected led=%b mode=%b tick=%b",
               name, led, mode, tick, expLed, expMode, expTick);
    end
  endtask

  task automatic modelCheck(input string name);
    checkOutput(name, modelLed(), 2'(mMode), modelTick());
  endtask

  task automatic finishCycle();
    bit edgeSeen;
    @(posedge clk);
    if (!rst_n) begin
      mMode = 0; mE = 0; mT = 0; mBtnPrev = 0;
    end else begin
      edgeSeen = btn_next && !mBtnPrev;
      if (edgeSeen) begin
        mMode = (mMode + 1) % 4;
        mE = 0;
        mT = 0;
      end else if (en) begin
        if ((mE % TD) == TD - 1) mT++;
        mE++;
      end
      mBtnPrev = btn_next;
    end
    @(negedge clk);
  endtask

  task automatic runCycles(input int n, input logic e, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, e);
      modelCheck(name);
      finishCycle();
    end
  endtask

  task automatic pulse(input string name);
    applyStimulus(1'b1, 1'b1);
    modelCheck(name);
    finishCycle();
    applyStimulus(1'b0, 1'b1);
    modelCheck(name);
    finishCycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mMode = 0; mE = 0; mT = 0; mBtnPrev = 0;

    vecs[0]  = '{1'b0, 1'b1, 3'b000, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'b000, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b000, 2'b00, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 3'b000, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b111, 2'b01, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b111, 2'b01, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b111, 2'b01, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b111, 2'b01, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 3'b110, 2'b01, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b110, 2'b01, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b110, 2'b01, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'b110, 2'b01, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 3'b101, 2'b01, 1'b0};

    rst_n = 1'b0;
    btn_next = 1'b0;
    en = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_hold", 3'b000, 2'b00, 1'b0);
    finishCycle();
    rst_n = 1'b1;

    // Start-up and first BLINK ticks from the table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].btn, vecs[i].en);
      checkOutput($sformatf("vec%0d", i), vecs[i].led, vecs[i].mode, vecs[i].tick);
      finishCycle();
    end

    runCycles(30, 1'b1, "blink_run");
    pulse("to_chase");
    runCycles(30, 1'b1, "chase_run");
    pulse("to_alt");
    applyStimulus(1'b0, 1'b1);
    checkOutput("alt_entry", 3'b101, 2'b11, 1'b0);
    finishCycle();
    runCycles(16, 1'b1, "alt_run");
    pulse("to_off");
    applyStimulus(1'b0, 1'b1);
    checkOutput("off_entry", 3'b000, 2'b00, modelTick());
    finishCycle();

    // Held button advances exactly once.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1);
      modelCheck("btn_held");
      finishCycle();
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("held_once", modelLed(), 2'b01, modelTick());
    finishCycle();

    // Back to OFF, then a button edge coinciding with a tick.
    pulse("blink_to_chase");
    pulse("chase_to_alt");
    pulse("alt_to_off");
    for (int i = 0; i < TD && ((mE % TD) != TD - 1); i++) begin
      applyStimulus(1'b0, 1'b1);
      modelCheck("align_tick");
      finishCycle();
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("edge_on_tick", 3'b000, 2'b00, 1'b1);
    finishCycle();
    applyStimulus(1'b0, 1'b1);
    checkOutput("after_edge_tick", 3'b111, 2'b01, 1'b0);
    finishCycle();
    runCycles(2, 1'b1, "post_clear");
    applyStimulus(1'b0, 1'b1);
    checkOutput("first_tick_after_clear", 3'b111, 2'b01, 1'b1);
    finishCycle();

    // Freeze in CHASE with en low, then resume.
    pulse("into_chase");
    runCycles(5, 1'b1, "chase_pre_freeze");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("frozen", modelLed(), 2'b10, 1'b0);
      finishCycle();
    end
    runCycles(20, 1'b1, "chase_resume");

    // Asynchronous reset between clock edges.
    applyStimulus(1'b0, 1'b1);
    modelCheck("pre_async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 3'b000, 2'b00, 1'b0);
    finishCycle();
    applyStimulus(1'b0, 1'b1);
    checkOutput("in_reset", 3'b000, 2'b00, 1'b0);
    finishCycle();
    rst_n = 1'b1;
    runCycles(TD, 1'b1, "post_reset");

    // Random button and enable activity.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0));
      modelCheck("random");
      finishCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
